// File: rtl/gcd_engine_if.sv
// Operand/result handshake bundle for gcd_engine: valid/ready on the operand
// side and on the result side, plus the result payload.
interface gcd_engine_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_gcd;
    logic [WIDTH-1:0] out_steps;
    logic             out_err;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_gcd, out_steps, out_err
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_gcd, out_steps, out_err
    );
endinterface

// File: rtl/gcd_engine.sv
// Unsigned GCD engine with selectable subtractive (MODE 0) or binary/Stein
// (MODE 1) iteration, one operand pair in flight, registered outputs.
module gcd_engine #(
    parameter int WIDTH = 16,
    parameter int MODE  = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    gcd_engine_if.slave bus
);
    localparam int KW = $clog2(WIDTH) + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q,     state_d;
    logic [WIDTH-1:0] a_q,         a_d;
    logic [WIDTH-1:0] b_q,         b_d;
    logic [KW-1:0]    k_q,         k_d;
    logic [WIDTH-1:0] steps_q,     steps_d;
    logic             in_ready_q,  in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_gcd_q,   out_gcd_d;
    logic [WIDTH-1:0] out_steps_q, out_steps_d;
    logic             out_err_q,   out_err_d;

    logic             a_zero_s;
    logic             b_zero_s;
    logic             equal_s;
    logic             a_gt_b_s;
    logic [WIDTH-1:0] diff_s;

    // Step counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        if (&v) begin
            r = v;
        end else begin
            r = v + {{(WIDTH-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    assign a_zero_s = (a_q == {WIDTH{1'b0}});
    assign b_zero_s = (b_q == {WIDTH{1'b0}});
    assign equal_s  = (a_q == b_q);
    assign a_gt_b_s = (a_q > b_q);
    // Always larger minus smaller, so the difference never underflows.
    assign diff_s   = a_gt_b_s ? (a_q - b_q) : (b_q - a_q);

    // Next-state and datapath update, one CALC action per cycle.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        k_d         = k_q;
        steps_d     = steps_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_gcd_d   = out_gcd_q;
        out_steps_d = out_steps_q;
        out_err_d   = out_err_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    a_d        = bus.in_a;
                    b_d        = bus.in_b;
                    k_d        = {KW{1'b0}};
                    steps_d    = {WIDTH{1'b0}};
                    in_ready_d = 1'b0;
                    state_d    = ST_CALC;
                end else begin
                    in_ready_d = 1'b1;
                end
            end

            ST_CALC: begin
                if (a_zero_s && b_zero_s) begin
                    out_gcd_d   = {WIDTH{1'b0}};
                    out_err_d   = 1'b1;
                    out_steps_d = steps_q;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else if (a_zero_s || b_zero_s) begin
                    out_gcd_d   = a_q | b_q;
                    out_err_d   = 1'b0;
                    out_steps_d = steps_q;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else if (equal_s) begin
                    // Binary mode restores the common power of two removed earlier.
                    out_gcd_d   = (MODE == 0) ? a_q : (a_q << k_q);
                    out_err_d   = 1'b0;
                    out_steps_d = steps_q;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    steps_d = sat_inc(steps_q);
                    if (MODE == 0) begin
                        if (a_gt_b_s) begin
                            a_d = diff_s;
                        end else begin
                            b_d = diff_s;
                        end
                    end else begin
                        if (!a_q[0] && !b_q[0]) begin
                            a_d = {1'b0, a_q[WIDTH-1:1]};
                            b_d = {1'b0, b_q[WIDTH-1:1]};
                            k_d = k_q + {{(KW-1){1'b0}}, 1'b1};
                        end else if (!a_q[0]) begin
                            a_d = {1'b0, a_q[WIDTH-1:1]};
                        end else if (!b_q[0]) begin
                            b_d = {1'b0, b_q[WIDTH-1:1]};
                        end else if (a_gt_b_s) begin
                            a_d = diff_s;
                        end else begin
                            b_d = diff_s;
                        end
                    end
                end
            end

            ST_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                in_ready_d  = 1'b0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers; reset abandons any operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            a_q         <= {WIDTH{1'b0}};
            b_q         <= {WIDTH{1'b0}};
            k_q         <= {KW{1'b0}};
            steps_q     <= {WIDTH{1'b0}};
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_gcd_q   <= {WIDTH{1'b0}};
            out_steps_q <= {WIDTH{1'b0}};
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            k_q         <= k_d;
            steps_q     <= steps_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_gcd_q   <= out_gcd_d;
            out_steps_q <= out_steps_d;
            out_err_q   <= out_err_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_gcd   = out_gcd_q;
    assign bus.out_steps = out_steps_q;
    assign bus.out_err   = out_err_q;
endmodule
